// File: rtl/ami_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ami_arb_pkg
// Shared types and helpers for the AMI request arbiter.
//   req_id_t    : requester id (1 bit), REQ_RD = read port, REQ_WR = write port
//   ami_req_t   : one request as held in the registered output stage
//   clog2       : ceiling log2 for parameter arithmetic
// The struct field widths below are the widest address/data/size the arbiter
// supports; the arbiter's ADDR_W/DATA_W/SIZE_W parameters must not exceed them.
// ---------------------------------------------------------------------------
package ami_arb_pkg;

    typedef logic req_id_t;

    localparam req_id_t REQ_RD = 1'b0;
    localparam req_id_t REQ_WR = 1'b1;

    localparam int AMI_ADDR_W = 32;
    localparam int AMI_DATA_W = 64;
    localparam int AMI_SIZE_W = 8;

    typedef struct packed {
        logic                  is_write;
        logic [AMI_ADDR_W-1:0] addr;
        logic [AMI_DATA_W-1:0] data;
        logic [AMI_SIZE_W-1:0] size;
    } ami_req_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ami_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// ami_arb_if
// Handshake bundle around the AMI request arbiter: the two requester request
// ports, the shared memory request/response port and the two requester
// response ports.
//   slave  : the arbiter's view (takes requests, drives the memory side)
//   master : the environment's view (accelerator + memory model)
// Packed per-requester vectors: requester i lives at [i*W +: W].
// ---------------------------------------------------------------------------
interface ami_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int SIZE_W = 8
);

    // requester -> arbiter
    logic [1:0]          req_valid;
    logic [1:0]          req_is_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_data;
    logic [2*SIZE_W-1:0] req_size;
    logic [1:0]          req_grant;

    // arbiter -> memory
    logic                mem_req_valid;
    logic                mem_req_is_write;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [DATA_W-1:0]   mem_req_data;
    logic [SIZE_W-1:0]   mem_req_size;
    logic                mem_req_ready;

    // memory -> arbiter
    logic                mem_resp_valid;
    logic [DATA_W-1:0]   mem_resp_data;
    logic                mem_resp_ready;

    // arbiter -> requester responses
    logic [1:0]          resp_valid;
    logic [DATA_W-1:0]   resp_data;
    logic [1:0]          resp_grant;

    modport slave (
        input  req_valid, req_is_write, req_addr, req_data, req_size,
        output req_grant,
        output mem_req_valid, mem_req_is_write, mem_req_addr, mem_req_data, mem_req_size,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_data,
        output mem_resp_ready,
        output resp_valid, resp_data,
        input  resp_grant
    );

    modport master (
        output req_valid, req_is_write, req_addr, req_data, req_size,
        input  req_grant,
        input  mem_req_valid, mem_req_is_write, mem_req_addr, mem_req_data, mem_req_size,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_data,
        input  mem_resp_ready,
        input  resp_valid, resp_data,
        output resp_grant
    );

endinterface

// File: rtl/ami_route_fifo.sv
// ---------------------------------------------------------------------------
// ami_route_fifo
// In-order FIFO of 1-bit requester ids. The head is visible combinationally so
// a response can be steered in the cycle it arrives.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   push, push_id    enqueue an id (ignored when full)
//   pop              dequeue the head (ignored when empty)
//   head_id          id at the head of the FIFO
//   empty, full      status
//   count            occupancy, 0..DEPTH
// DEPTH must be a power of two; the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ami_route_fifo
    import ami_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  req_id_t                  push_id,
    input  logic                     pop,
    output req_id_t                  head_id,
    output logic                     empty,
    output logic                     full,
    output logic [clog2(DEPTH):0]    count
);

    localparam int PTR_W = clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [DEPTH-1:0] slot_vec;
    logic             push_en;
    logic             pop_en;

    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;

    // One register per entry, written only when the write pointer selects it.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            req_id_t slot_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    slot_reg <= REQ_RD;
                end else if (push_en && (wr_ptr_reg == PTR_W'(gi))) begin
                    slot_reg <= push_id;
                end
            end
            assign slot_vec[gi] = slot_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_id = slot_vec[rd_ptr_reg];
    assign empty   = (count_reg == '0);
    // Occupancy never exceeds DEPTH = 2**PTR_W, so the MSB alone marks full.
    assign full    = count_reg[PTR_W];
    assign count   = count_reg;

endmodule

// File: rtl/ami_req_arbiter.sv
// ---------------------------------------------------------------------------
// ami_req_arbiter
// Shares one AMI memory port between requester 0 (reads) and requester 1
// (writes). A round-robin arbiter loads a one-entry registered output stage;
// a route FIFO remembers the owner of every issued request so in-order memory
// responses are steered back to the right requester.
// Ports:
//   clk               clock
//   rst               asynchronous active-low reset
//   bus (slave)       request, memory and response handshakes (ami_arb_if)
//   outstanding       issued-but-unanswered request count (route FIFO level)
//   grant_cnt0/1      per-requester grant counters
//   stall_cnt         cycles with a pending request and no grant
// Optional feature macro: AMI_ARB_PERF_EN enables the saturating performance
// counters; without it the three counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module ami_req_arbiter
    import ami_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int SIZE_W  = 8,
    parameter int MAX_OUT = 8,
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    ami_arb_if.slave                bus,
    output logic [clog2(MAX_OUT):0] outstanding,
    output logic [CNT_W-1:0]        grant_cnt0,
    output logic [CNT_W-1:0]        grant_cnt1,
    output logic [CNT_W-1:0]        stall_cnt
);

    // ---------------------------------------------------------------------
    // Per-requester candidate requests, unpacked from the packed buses
    // ---------------------------------------------------------------------
    ami_req_t cand [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cand
            assign cand[gi].is_write = bus.req_is_write[gi];
            assign cand[gi].addr     = AMI_ADDR_W'(bus.req_addr[gi*ADDR_W +: ADDR_W]);
            assign cand[gi].data     = AMI_DATA_W'(bus.req_data[gi*DATA_W +: DATA_W]);
            assign cand[gi].size     = AMI_SIZE_W'(bus.req_size[gi*SIZE_W +: SIZE_W]);
        end
    endgenerate

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    ami_req_t stage_reg;
    logic     mem_req_valid_reg;
    req_id_t  last_reg;

    logic     fifo_empty;
    logic     fifo_full;
    req_id_t  head_id;
    logic     fifo_pop;

    logic     slot_free;
    logic     can_accept;
    logic     grant_any;
    req_id_t  grant_id;
    logic [1:0] req_grant_int;

    // ---------------------------------------------------------------------
    // Arbitration
    // can_accept deliberately ignores a same-cycle response pop so the grant
    // path does not depend on the response handshake.
    // ---------------------------------------------------------------------
    assign slot_free  = ~mem_req_valid_reg | bus.mem_req_ready;
    assign can_accept = slot_free & ~fifo_full;

    always_comb begin
        grant_any = 1'b0;
        grant_id  = REQ_RD;
        if (can_accept) begin
            if (bus.req_valid[0] && bus.req_valid[1]) begin
                grant_any = 1'b1;
                grant_id  = ~last_reg;
            end else if (bus.req_valid[0]) begin
                grant_any = 1'b1;
                grant_id  = REQ_RD;
            end else if (bus.req_valid[1]) begin
                grant_any = 1'b1;
                grant_id  = REQ_WR;
            end
        end
    end

    always_comb begin
        req_grant_int = 2'b00;
        if (grant_any) begin
            req_grant_int = (grant_id == REQ_WR) ? 2'b10 : 2'b01;
        end
    end

    assign bus.req_grant = req_grant_int;

    // ---------------------------------------------------------------------
    // Registered output stage. A grant in the same cycle as a fire reloads
    // the stage directly, so back-to-back requests have no bubble.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_reg         <= '0;
            mem_req_valid_reg <= 1'b0;
            last_reg          <= REQ_WR;   // requester 0 wins the first tie
        end else begin
            if (grant_any) begin
                stage_reg         <= cand[grant_id];
                mem_req_valid_reg <= 1'b1;
                last_reg          <= grant_id;
            end else if (bus.mem_req_ready) begin
                mem_req_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.mem_req_valid    = mem_req_valid_reg;
    assign bus.mem_req_is_write = stage_reg.is_write;
    assign bus.mem_req_addr     = stage_reg.addr[ADDR_W-1:0];
    assign bus.mem_req_data     = stage_reg.data[DATA_W-1:0];
    assign bus.mem_req_size     = stage_reg.size[SIZE_W-1:0];

    // ---------------------------------------------------------------------
    // Route FIFO and response steering
    // ---------------------------------------------------------------------
    ami_route_fifo #(
        .DEPTH (MAX_OUT)
    ) u_route_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (grant_any),
        .push_id (grant_id),
        .pop     (fifo_pop),
        .head_id (head_id),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (outstanding)
    );

    logic       resp_hit;
    logic [1:0] resp_valid_int;

    // A response with nothing outstanding is dropped: no valid, no ready.
    assign resp_hit = bus.mem_resp_valid & ~fifo_empty;

    always_comb begin
        resp_valid_int = 2'b00;
        if (resp_hit) begin
            resp_valid_int = (head_id == REQ_WR) ? 2'b10 : 2'b01;
        end
    end

    assign bus.resp_valid     = resp_valid_int;
    assign bus.resp_data      = bus.mem_resp_data;
    assign bus.mem_resp_ready = ~fifo_empty & bus.resp_grant[head_id];
    assign fifo_pop           = bus.mem_resp_valid & bus.mem_resp_ready;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && bus.mem_resp_valid && fifo_empty) begin
            $display("%m: note: mem_resp_valid with no outstanding request, response ignored (t=%0t)", $time);
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Performance counters (saturating)
    // ---------------------------------------------------------------------
`ifdef AMI_ARB_PERF_EN
    logic [CNT_W-1:0] grant_cnt_vec [2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (req_grant_int[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
            assign grant_cnt_vec[gi] = cnt_reg;
        end
    endgenerate

    logic [CNT_W-1:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
        end else if ((|bus.req_valid) && !grant_any && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign grant_cnt0 = grant_cnt_vec[0];
    assign grant_cnt1 = grant_cnt_vec[1];
    assign stall_cnt  = stall_cnt_reg;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
    assign stall_cnt  = '0;
`endif

endmodule

// File: doc/ami_req_arbiter.md
Name: ami_req_arbiter

Overview:
- Shares one AMI memory port between two requesters of the accelerator top: port 0 (read requests) and port 1 (write requests).
- Round-robin arbitration feeds a one-entry registered output stage.
- An in-order route FIFO records which requester owns each issued request, so memory responses are steered back to the correct response port.
- Sits between the accelerator top and the memory system model in the drive harness.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 64, request/response data width
- SIZE_W, 8, request size field width
- MAX_OUT, 8, maximum outstanding (issued, unanswered) requests; power of two ≥2
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_is_write  in  2  per-requester write flag
- req_addr  in  2*ADDR_W  per-requester address, packed, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  2*DATA_W  per-requester write data, packed
- req_size  in  2*SIZE_W  per-requester size, packed
- req_grant  out  2  one-hot accept strobe; request consumed in that cycle
- mem_req_valid  out  1  output request valid (registered)
- mem_req_is_write  out  1  registered
- mem_req_addr  out  ADDR_W  registered
- mem_req_data  out  DATA_W  registered
- mem_req_size  out  SIZE_W  registered
- mem_req_ready  in  1  memory accepts the output request when valid&ready
- mem_resp_valid  in  1  memory response valid
- mem_resp_data  in  DATA_W  memory response data
- mem_resp_ready  out  1  response accepted by the arbiter
- resp_valid  out  2  per-requester response valid
- resp_data  out  DATA_W  response data, shared by both ports
- resp_grant  in  2  per-requester response accept
- outstanding  out  log2(MAX_OUT)+1  route FIFO occupancy
- grant_cnt0, grant_cnt1  out  CNT_W  performance counters, see Optional Feature
- stall_cnt  out  CNT_W  performance counter, see Optional Feature

Behaviour:
- Reset (rst=0, async):
  - mem_req_valid=0, all mem_req_* fields=0.
  - Route FIFO empty, outstanding=0.
  - Round-robin pointer last=1, so requester 0 wins first.
  - All counters 0.
- Slot free: slot_free = !mem_req_valid | mem_req_ready.
- Accept condition: can_accept = slot_free & (outstanding < MAX_OUT).
  - Not gated by the same-cycle response pop; this keeps the path simple, a deliberate choice.
- Arbitration (combinational):
  - Both requesters valid: grant requester !last.
  - One requester valid: grant it.
  - req_grant is zero when !can_accept.
  - At most one req_grant bit is ever set.
- On a grant:
  - Selected fields are registered into the output stage next edge; mem_req_valid=1.
  - Requester id is pushed into the route FIFO.
  - last <= granted id.
- Output stage:
  - Holds stable while mem_req_valid & !mem_req_ready.
  - Fire and no new grant: mem_req_valid <= 0.
  - Fire and new grant in the same cycle: back-to-back, no bubble.
  - Latency: request granted at edge N is presented from N+1.
  - Throughput: 1 per cycle.
- Responses:
  - Every request, read or write, gets exactly one response, in issue order.
  - head = route FIFO head id.
  - resp_valid[head] = mem_resp_valid & !empty; the other bit is 0.
  - resp_data = mem_resp_data (pass-through, zero latency).
  - mem_resp_ready = !empty & resp_grant[head].
  - Pop on mem_resp_valid & mem_resp_ready.
- Simultaneous push and pop: occupancy unchanged; both pointers advance.
- Pointers: log2(MAX_OUT) bits, natural wrap; occupancy tracked in a separate counter.
- Error case: mem_resp_valid while empty is a protocol error. Response is ignored, mem_resp_ready=0, and a simulation $display is issued.
- Reset mid-operation: all in-flight state discarded; responses arriving later are ignored as above.

Optional Feature:
- Macro: AMI_ARB_PERF_EN.
- Defined:
  - grant_cntI increments on each req_grant[I].
  - stall_cnt increments each cycle in which any req_valid is set and no grant occurs.
  - Counters saturate at all-ones.
- Undefined: counter logic is absent; the three outputs are tied to 0.

Decomposition:
- Shared package ami_arb_pkg:
  - requester id typedef (1 bit), REQ_RD=0, REQ_WR=1.
  - Output-stage request struct typedef (is_write, addr, data, size).
  - Helper function clog2.
- Sub-module ami_route_fifo: synchronous FIFO, parameter DEPTH=MAX_OUT, width 1, with push/pop/empty/full/count; reset is async active-low on rst.

Test Plan:
- Single read: req_valid=01, addr 0x100, mem_req_ready=1.
  - req_grant=01 same cycle; mem_req_valid with addr 0x100 next cycle.
  - Response data 0xAB returns on resp_valid=01; outstanding goes 1 then 0.
- Contention: req_valid=11 held 4 cycles, ready=1.
  - Grants alternate 01,10,01,10.
  - Output order alternates read/write.
- Backpressure: mem_req_ready=0 for 5 cycles with one request in the stage.
  - Output fields stable.
  - req_grant=00 while the slot is full.
  - Release: back-to-back issue with no bubble.
- Outstanding limit: issue 8 requests with no responses.
  - 9th request not granted; outstanding=8.
  - One response returned: grant resumes next cycle.
- Response routing: issue R,W,R; return 3 responses with resp_grant=11.
  - resp_valid sequence 01,10,01.
  - With resp_grant[1]=0, the write response stalls and mem_resp_ready=0.
- Async reset mid-burst: drop rst low with outstanding=3 and mem_req_valid=1.
  - Outputs clear immediately without a clock edge.
  - A later stray response is ignored.
  - With AMI_ARB_PERF_EN defined, counters read 0.
